// File: rtl/panel_pkg.sv
// Shared constants and event encodings for the panel input conditioner.
package panel_pkg;

    localparam int EVT_CODE_W = 3;
    localparam int IN_W       = 4;
    // Pending vector layout: [0] DIP, then press, long, release banks of IN_W bits.
    localparam int PEND_W     = 1 + 3 * IN_W;

    typedef enum logic [EVT_CODE_W-1:0] {
        EVT_NONE       = 3'd0,
        EVT_DIP_CHANGE = 3'd1,
        EVT_PB_PRESS   = 3'd2,
        EVT_PB_RELEASE = 3'd3,
        EVT_PB_LONG    = 3'd4
    } evt_code_e;

endpackage

// File: rtl/panel_input_ctrl_debounce_bit.sv
// One-bit 2-flop synchroniser plus debounce counter; RST_VAL is the idle pin level.
module debounce_bit #(
    parameter int   DEB_CYC = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic o_clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_upd
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_hit;

    assign w_diff   = (r_s2 != r_stable);
    assign w_hit    = (r_cnt == CW'(DEB_CYC - 1));
    assign o_upd    = w_diff && w_hit;
    assign o_stable = r_stable;

    always_ff @(posedge o_clk or posedge rst) begin
        if (rst) begin
            r_s1     <= RST_VAL;
            r_s2     <= RST_VAL;
            r_stable <= RST_VAL;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_hit) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/panel_input_ctrl.sv
// Debounces DIP switches and push buttons and queues change events over valid/ready.
// Optional long-press events are built when PANEL_LONG_PRESS_EN is defined.
module panel_input_ctrl
    import panel_pkg::*;
#(
    parameter int   DEB_CYC       = 4,
    parameter int   LONG_CYC      = 16,
    parameter logic PB_ACTIVE_LOW = 1'b1
) (
    input  logic                  o_clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       dip_raw,
    input  logic [IN_W-1:0]       pb_raw,
    output logic [IN_W-1:0]       dip_stable,
    output logic [IN_W-1:0]       pb_level,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [EVT_CODE_W-1:0] evt_code,
    output logic [IN_W-1:0]       evt_data,
    output logic                  evt_ovf,
    input  logic                  evt_ovf_clr
);

    logic [IN_W-1:0]   w_dip_upd;
    logic [IN_W-1:0]   w_pb_stable;
    logic [IN_W-1:0]   w_pb_upd;
    logic [IN_W-1:0]   w_long_set;
    logic [PEND_W-1:0] w_set;
    logic [PEND_W-1:0] w_sel;
    logic [PEND_W-1:0] w_clr;
    logic [PEND_W-1:0] r_pend;
    logic              w_load;
    logic              w_ovf_set;
    evt_code_e         w_code;
    logic [IN_W-1:0]   w_data;

    logic              r_valid;
    evt_code_e         r_code;
    logic [IN_W-1:0]   r_data;
    logic              r_ovf;

    genvar g;
    generate
        for (g = 0; g < IN_W; g++) begin : g_deb
            debounce_bit #(.DEB_CYC(DEB_CYC), .RST_VAL(1'b0)) u_dip (
                .o_clk    (o_clk),
                .rst      (rst),
                .i_raw    (dip_raw[g]),
                .o_stable (dip_stable[g]),
                .o_upd    (w_dip_upd[g])
            );
            debounce_bit #(.DEB_CYC(DEB_CYC), .RST_VAL(PB_ACTIVE_LOW)) u_pb (
                .o_clk    (o_clk),
                .rst      (rst),
                .i_raw    (pb_raw[g]),
                .o_stable (w_pb_stable[g]),
                .o_upd    (w_pb_upd[g])
            );
        end
    endgenerate

    assign pb_level = w_pb_stable ^ {IN_W{PB_ACTIVE_LOW}};

`ifdef PANEL_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYC + 1);

    logic [LW-1:0] r_long_cnt [IN_W];

    always_ff @(posedge o_clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < IN_W; i++) r_long_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < IN_W; i++) begin
                if (!pb_level[i])
                    r_long_cnt[i] <= '0;
                else if (r_long_cnt[i] != LW'(LONG_CYC))
                    r_long_cnt[i] <= r_long_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        w_long_set = '0;
        for (int unsigned i = 0; i < IN_W; i++)
            w_long_set[i] = pb_level[i] && (r_long_cnt[i] == LW'(LONG_CYC - 1));
    end
`else
    assign w_long_set = '0;
`endif

    // Update strobes fire before pb_level changes, so the current level tells the direction.
    assign w_set = {w_pb_upd & pb_level, w_long_set, w_pb_upd & ~pb_level, |w_dip_upd};

    // Lowest index wins: DIP, then presses, long presses, releases.
    always_comb begin
        w_sel  = '0;
        w_code = EVT_NONE;
        w_data = '0;
        for (int unsigned i = 0; i < PEND_W; i++) begin
            if (r_pend[i] && (w_sel == '0)) begin
                w_sel[i] = 1'b1;
                if (i == 0) begin
                    w_code = EVT_DIP_CHANGE;
                    w_data = dip_stable;
                end else begin
                    w_data = IN_W'(1) << ((i - 1) % IN_W);
                    if (i <= IN_W)          w_code = EVT_PB_PRESS;
                    else if (i <= 2 * IN_W) w_code = EVT_PB_LONG;
                    else                    w_code = EVT_PB_RELEASE;
                end
            end
        end
    end

    assign w_load    = !r_valid || evt_ready;
    assign w_clr     = w_load ? w_sel : '0;
    assign w_ovf_set = |(w_set & r_pend & ~w_clr);

    always_ff @(posedge o_clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_code  <= EVT_NONE;
            r_data  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (w_load) begin
                r_valid <= |r_pend;
                r_code  <= w_code;
                r_data  <= w_data;
            end
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (evt_ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign evt_valid = r_valid;
    assign evt_code  = r_code;
    assign evt_data  = r_data;
    assign evt_ovf   = r_ovf;

endmodule

// File: tb/tb_panel_input_ctrl.sv
// Directed bench for panel_input_ctrl; long-press checks build with PANEL_LONG_PRESS_EN.
module tb_panel_input_ctrl;

    logic       o_clk = 1'b0;
    logic       rst;
    logic [3:0] dip_raw;
    logic [3:0] pb_raw;
    logic [3:0] dip_stable;
    logic [3:0] pb_level;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_code;
    logic [3:0] evt_data;
    logic       evt_ovf;
    logic       evt_ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;

    panel_input_ctrl #(.DEB_CYC(4), .LONG_CYC(16), .PB_ACTIVE_LOW(1'b1)) dut (
        .o_clk       (o_clk),
        .rst         (rst),
        .dip_raw     (dip_raw),
        .pb_raw      (pb_raw),
        .dip_stable  (dip_stable),
        .pb_level    (pb_level),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_code    (evt_code),
        .evt_data    (evt_data),
        .evt_ovf     (evt_ovf),
        .evt_ovf_clr (evt_ovf_clr)
    );

    always #5 o_clk = ~o_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge o_clk);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic v, input logic [2:0] c, input logic [3:0] d);
        check({tag, "_valid"}, evt_valid, v);
        check({tag, "_code"},  evt_code,  c);
        check({tag, "_data"},  evt_data,  d);
    endtask

    initial begin
        int n;
        int press_cyc;
        int long_cyc;
        int n_long;
        int rel_seen;

        rst = 1'b1; dip_raw = 4'h0; pb_raw = 4'hF; evt_ready = 1'b1; evt_ovf_clr = 1'b0;
        #2;
        check("rst_dip",   dip_stable, 4'h0);
        check("rst_pb",    pb_level,   4'h0);
        check("rst_ovf",   evt_ovf,    1'b0);
        check_slot("rst", 1'b0, 3'd0, 4'h0);
        tick(3);
        rst = 1'b0;
        tick(4);
        check_slot("idle", 1'b0, 3'd0, 4'h0);

        // DIP change: stable at edge 6, event at edge 7 for one cycle
        dip_raw = 4'b1001;
        tick(5);
        check("dip_e5", dip_stable, 4'h0);
        tick(1);
        check("dip_e6", dip_stable, 4'b1001);
        check("dip_e6_valid", evt_valid, 1'b0);
        tick(1);
        check_slot("dip_e7", 1'b1, 3'd1, 4'b1001);
        tick(1);
        check_slot("dip_e8", 1'b0, 3'd0, 4'h0);

        // Three-cycle glitch on PB2 is filtered
        pb_raw = 4'b1011;
        tick(3);
        pb_raw = 4'hF;
        n = 0;
        repeat (12) begin
            tick(1);
            if (evt_valid || pb_level != 4'h0) n++;
        end
        check("glitch", n, 0);

        // PB0 press 10 cycles: press then release, no long
        pb_raw = 4'b1110;
        tick(6);
        check("pb0_level", pb_level, 4'b0001);
        tick(1);
        check_slot("pb0_press", 1'b1, 3'd2, 4'b0001);
        tick(3);
        pb_raw = 4'hF;
        tick(6);
        check("pb0_level_rel", pb_level, 4'h0);
        tick(1);
        check_slot("pb0_rel", 1'b1, 3'd3, 4'b0001);
        n = 0;
        repeat (25) begin
            tick(1);
            if (evt_valid) n++;
        end
        check("pb0_no_extra", n, 0);

        // Back-pressure: slot holds first DIP, second pends, third overflows
        evt_ready = 1'b0;
        dip_raw = 4'b0011;
        tick(7);
        check_slot("bp_dip1", 1'b1, 3'd1, 4'b0011);
        pb_raw = 4'b1101;
        tick(7);
        dip_raw = 4'b0101;
        tick(7);
        check("bp_ovf0", evt_ovf, 1'b0);
        dip_raw = 4'b0110;
        tick(7);
        check("bp_ovf1", evt_ovf, 1'b1);
        check_slot("bp_hold", 1'b1, 3'd1, 4'b0011);
        evt_ready = 1'b1;
        tick(1);
        check_slot("bp_dip2", 1'b1, 3'd1, 4'b0110);
        tick(1);
        check_slot("bp_press", 1'b1, 3'd2, 4'b0010);
        tick(1);
        check("bp_empty", evt_valid, 1'b0);
        evt_ovf_clr = 1'b1;
        tick(1);
        evt_ovf_clr = 1'b0;
        check("ovf_clr", evt_ovf, 1'b0);
        pb_raw = 4'hF;
        tick(7);
        check_slot("bp_rel", 1'b1, 3'd3, 4'b0010);
        tick(1);
        check("bp_rel_done", evt_valid, 1'b0);

        // Clear arriving with a new overflow keeps the flag set
        evt_ready = 1'b0;
        dip_raw = 4'b0000;
        tick(7);
        dip_raw = 4'b0001;
        tick(7);
        dip_raw = 4'b0011;
        tick(5);
        evt_ovf_clr = 1'b1;
        tick(1);
        evt_ovf_clr = 1'b0;
        check("ovf_clr_race", evt_ovf, 1'b1);
        check_slot("race_hold", 1'b1, 3'd1, 4'b0000);
        evt_ready = 1'b1;
        tick(1);
        check_slot("race_dip", 1'b1, 3'd1, 4'b0011);
        tick(1);
        check("race_empty", evt_valid, 1'b0);
        evt_ovf_clr = 1'b1;
        tick(1);
        evt_ovf_clr = 1'b0;

        // Reset while an event is held with PB2 pressed
        evt_ready = 1'b0;
        pb_raw = 4'b1011;
        tick(7);
        check_slot("pre_rst", 1'b1, 3'd2, 4'b0100);
        #1 rst = 1'b1;
        #1;
        check_slot("mid_rst", 1'b0, 3'd0, 4'h0);
        check("mid_rst_pb",  pb_level,   4'h0);
        check("mid_rst_dip", dip_stable, 4'h0);
        tick(2);
        rst = 1'b0;
        tick(7);
        check_slot("post_rst_dip", 1'b1, 3'd1, 4'b0011);
        evt_ready = 1'b1;
        tick(1);
        check_slot("post_rst_press", 1'b1, 3'd2, 4'b0100);
        pb_raw = 4'hF;
        tick(12);
        check("post_rst_drained", evt_valid, 1'b0);

`ifdef PANEL_LONG_PRESS_EN
        press_cyc = -1; long_cyc = -1; n_long = 0; rel_seen = 0;
        pb_raw = 4'b0111;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (evt_valid && evt_code == 3'd2 && evt_data == 4'b1000) press_cyc = c;
            if (evt_valid && evt_code == 3'd4) begin
                n_long++;
                long_cyc = c;
                check("long_data", evt_data, 4'b1000);
            end
        end
        pb_raw = 4'hF;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (evt_valid && evt_code == 3'd3 && evt_data == 4'b1000) rel_seen++;
        end
        check("long_press_cyc", press_cyc, 7);
        check("long_count", n_long, 1);
        check("long_delay", long_cyc - press_cyc, 16);
        check("long_rel", rel_seen, 1);
`else
        press_cyc = 0; long_cyc = 0; n_long = 0; rel_seen = 0;
        pb_raw = 4'b0111;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (evt_valid && evt_code == 3'd4) n_long++;
            if (evt_valid && evt_code == 3'd2) press_cyc = c;
        end
        pb_raw = 4'hF;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (evt_valid && evt_code == 3'd3) rel_seen++;
        end
        check("nolong_press_cyc", press_cyc, 7);
        check("nolong_count", n_long, 0);
        check("nolong_rel", rel_seen, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
